multicycle_adder: RTL and testbench



---
 rtl/multicycle_adder.sv | 82 ++++++++
 tb/tb_multicycle_adder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_adder.sv
// multicycle_adder: digit-serial adder/subtractor, LSD first, with valid/ready on both sides.
module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);
  localparam int NSTEP = WIDTH / DIGIT;
  localparam int SW = $clog2(NSTEP) + 1;
  if (WIDTH < 2 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_params
    $error("multicycle_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_r, b_r;
  logic carry;
  logic [SW-1:0] step;
  logic [DIGIT-1:0] dsum;
  logic [DIGIT:0] c;
  logic accept, last;
  logic [WIDTH+DIGIT-1:0] shifted;
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign accept = in_valid && in_ready;
  assign last = step == SW'(NSTEP - 1);
  assign out_valid = state == DONE;
  // ripple-carry slice of full adders fed by the registered carry
  assign c[0] = carry;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign dsum[i] = a_r[i] ^ b_r[i] ^ c[i];
    assign c[i+1] = (a_r[i] & b_r[i]) | (c[i] & (a_r[i] ^ b_r[i]));
  end
  assign shifted = {dsum, Sum};
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = accept ? RUN : IDLE;
      RUN: state_nx = last ? DONE : RUN;
      DONE: state_nx = accept ? RUN : (out_ready ? IDLE : DONE);
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      carry <= 1'b0;
      step <= '0;
      Sum <= '0;
      Cout <= 1'b0;
      Ovf <= 1'b0;
    end else if (accept) begin
      a_r <= a;
      b_r <= sub ? ~b : b;
      carry <= cin ^ sub;
      step <= '0;
    end else if (state == RUN) begin
      a_r <= a_r >> DIGIT;
      b_r <= b_r >> DIGIT;
      carry <= c[DIGIT];
      step <= step + SW'(1);
      Sum <= shifted[WIDTH+DIGIT-1:DIGIT];
      if (last) begin
        Cout <= c[DIGIT];
        Ovf <= c[DIGIT] ^ c[DIGIT-1];
      end
    end
endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder: random and directed stimulus against an arithmetic reference model.
module tb_multicycle_adder;
  localparam int W = 16;
  localparam int D = 4;
  localparam int N = W / D;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
  logic out_valid, out_ready = 1'b0, Cout, Ovf;
  logic [W-1:0] a = '0, b = '0, Sum;
  logic f_in_valid = 1'b0, f_in_ready, f_cin = 1'b0, f_sub = 1'b0;
  logic f_out_valid, f_out_ready = 1'b1, f_Cout, f_Ovf;
  logic [W-1:0] f_a = '0, f_b = '0, f_Sum;
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
  logic [W+1:0] q[$];
  logic m_run = 1'b0, m_valid = 1'b0;
  int m_left = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multicycle_adder #(.WIDTH(W), .DIGIT(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
  );
  multicycle_adder #(.WIDTH(W), .DIGIT(W)) dut_full (
    .clk(clk), .rst_n(rst_n), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .a(f_a), .b(f_b), .cin(f_cin), .sub(f_sub), .out_valid(f_out_valid),
    .out_ready(f_out_ready), .Sum(f_Sum), .Cout(f_Cout), .Ovf(f_Ovf)
  );

  // returns {Ovf, Cout, Sum} from integer arithmetic on the operands
  function automatic logic [W+1:0] model(input logic [W-1:0] x, y, input logic ci, su);
    int u, s;
    u = su ? int'(x) - int'(y) - int'(ci) : int'(x) + int'(y) + int'(ci);
    s = su ? int'($signed(x)) - int'($signed(y)) - int'(ci)
           : int'($signed(x)) + int'($signed(y)) + int'(ci);
    return {s > 2**(W-1) - 1 || s < -(2**(W-1)), su ? u >= 0 : u >= 2**W, W'(u)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : model_p
    logic acc, hs;
    if (!rst_n) begin
      q.delete();
      m_run = 1'b0;
      m_valid = 1'b0;
      m_left = 0;
    end else begin
      acc = in_valid && !m_run && (!m_valid || out_ready);
      hs = m_valid && out_ready;
      if (hs) begin
        m_valid = 1'b0;
        void'(q.pop_front());
      end
      if (m_run) begin
        m_left--;
        if (m_left == 0) begin
          m_run = 1'b0;
          m_valid = 1'b1;
        end
      end
      if (acc) begin
        q.push_back(model(a, b, cin, sub));
        m_run = 1'b1;
        m_left = N;
      end
    end
  end

  always @(negedge clk) if (rst_n) begin
    check("in_ready", in_ready, !m_run && (!m_valid || out_ready));
    check("out_valid", out_valid, m_valid);
    if (m_valid && q.size() > 0) check("result", {Ovf, Cout, Sum}, q[0]);
  end

  task automatic send(input logic [W-1:0] x, y, input logic ci, su);
    @(posedge clk); #1;
    in_valid = 1'b1; a = x; b = y; cin = ci; sub = su;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check("send_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_valid();
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("wait_valid", out_valid, 1);
  endtask

  task automatic get(input string name, input logic [W-1:0] es, input logic ec, eo);
    wait_valid();
    check({name, "_sum"}, Sum, es);
    check({name, "_cout"}, Cout, ec);
    check({name, "_ovf"}, Ovf, eo);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run16(input logic [W-1:0] x, y, input logic ci, su);
    logic [W+1:0] e;
    e = model(x, y, ci, su);
    @(posedge clk); #1;
    f_in_valid = 1'b1; f_a = x; f_b = y; f_cin = ci; f_sub = su;
    @(negedge clk);
    check("f_in_ready", f_in_ready, 1);
    @(posedge clk); #1;
    f_in_valid = 1'b0;
    @(negedge clk);
    check("f_run", f_out_valid, 0);
    @(negedge clk);
    check("f_valid", f_out_valid, 1);
    check("f_result", {f_Ovf, f_Cout, f_Sum}, e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rdy;
    check("model_wrap", model(16'hFFFF, 16'h0001, 0, 0), {1'b0, 1'b1, 16'h0000});
    check("model_ovf", model(16'h7FFF, 16'h0001, 0, 0), {1'b1, 1'b0, 16'h8000});
    check("model_cin", model(16'h8000, 16'hFFFF, 1, 0), {1'b0, 1'b1, 16'h8000});
    check("model_borrow", model(16'h0005, 16'h0007, 0, 1), {1'b0, 1'b0, 16'hFFFE});
    check("model_subcin", model(16'h0007, 16'h0005, 1, 1), {1'b0, 1'b1, 16'h0001});
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", Sum, 0);
    check("rst_cout", Cout, 0);
    check("rst_ovf", Ovf, 0);
    check("rst_f_out_valid", f_out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    send(16'hFFFF, 16'h0001, 0, 0);
    wait_valid();
    check("latency", cyc - acc_cyc, N);
    get("wrap", 16'h0000, 1, 0);
    send(16'h7FFF, 16'h0001, 0, 0);
    get("ovf", 16'h8000, 0, 1);
    send(16'h8000, 16'hFFFF, 1, 0);
    get("cin", 16'h8000, 1, 0);
    send(16'h0005, 16'h0007, 0, 1);
    get("borrow", 16'hFFFE, 0, 0);
    send(16'h0007, 16'h0005, 1, 1);
    get("subcin", 16'h0001, 1, 0);

    send(16'h00FF, 16'h0F0F, 0, 0);
    wait_valid();
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h5555; sub = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_sum", Sum, 16'h100E);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_still_valid", out_valid, 1);
    @(negedge clk);
    check("bp_dropped", out_valid, 0);
    check("bp_sum_kept", Sum, 16'h100E);
    @(posedge clk); #1;
    out_ready = 1'b0;

    send(16'h0001, 16'h0002, 0, 0);
    wait_valid();
    @(posedge clk); #1;
    in_valid = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("b2b_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int j = 0; j <= N; j++) begin
      @(negedge clk);
      check("b2b_timing", out_valid, j == N);
    end
    check("b2b_sum", Sum, 16'h2345);
    get("b2b", 16'h2345, 0, 0);

    send(16'h1111, 16'h2222, 0, 0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_sum", Sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_no_result", out_valid, 0);

    rdy = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      if (!in_valid || rdy) begin
        in_valid = ($urandom % 2) == 1;
        a = W'($urandom);
        b = W'($urandom);
        cin = ($urandom % 2) == 1;
        sub = ($urandom % 2) == 1;
      end
      out_ready = ($urandom % 4) != 0;
    end
    @(negedge clk);
    rdy = in_ready;
    @(posedge clk); #1;
    if (in_valid && !rdy) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 40 && (q.size() != 0 || m_run); t++) @(negedge clk);
    check("drain", q.size(), 0);
    @(posedge clk); #1;
    out_ready = 1'b0;

    run16(16'hFFFF, 16'h0001, 0, 0);
    check("f_wrap", {f_Ovf, f_Cout, f_Sum}, 18'h10000);
    run16(16'h7FFF, 16'h0001, 0, 0);
    run16(16'h0005, 16'h0007, 0, 1);
    for (int i = 0; i < 20; i++)
      run16(W'($urandom), W'($urandom), ($urandom % 2) == 1, ($urandom % 2) == 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
